// File: rtl/periferico_fifo_if.sv
// Bus bundle between the CPU-side sender / peripheral consumer and periferico_fifo.
// The FIFO takes the slave view; whatever drives per_send and per_pop takes the master view.
interface periferico_fifo_if #(
   parameter int DATA_W = 4,
   parameter int DEPTH  = 8,
   parameter int CNT_W  = 8
);
   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic              per_send;
   logic [DATA_W-1:0] per_dados_in;
   logic              per_ack;
   logic              per_pop;
   logic [DATA_W-1:0] per_dados_out;
   logic              per_empty;
   logic              per_full;
   logic [LVL_W-1:0]  per_level;
   logic              per_underflow;
   logic [CNT_W-1:0]  per_rx_count;

   modport slave (
      input  per_send, per_dados_in, per_pop,
      output per_ack, per_dados_out, per_empty, per_full,
             per_level, per_underflow, per_rx_count
   );

   modport master (
      output per_send, per_dados_in, per_pop,
      input  per_ack, per_dados_out, per_empty, per_full,
             per_level, per_underflow, per_rx_count
   );
endinterface

// File: rtl/periferico_fifo.sv
// Receiver for the CPU->peripheral 4-phase send/ack handshake, buffering words in a
// DEPTH-entry first-word-fall-through FIFO so the sender is not stalled by a busy consumer.
module periferico_fifo #(
   parameter int DATA_W = 4,
   parameter int DEPTH  = 8,
   parameter int CNT_W  = 8
) (
   input  logic               per_clock,
   input  logic               per_reset,
   periferico_fifo_if.slave   bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   typedef enum logic {S_IDLE, S_ACK} state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [LVL_W-1:0]  r_level;
   logic              r_underflow;
   logic [CNT_W-1:0]  r_rx_count;
   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;
   logic              w_ack;

   // Full is judged on the registered level, so a same-cycle pop never makes room for a push.
   assign w_full  = (r_level == LVL_W'(DEPTH));
   assign w_empty = (r_level == '0);
   assign w_pop   = bus.per_pop && !w_empty;

   always_comb begin
      w_state_next = r_state;
      w_push       = 1'b0;
      w_ack        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.per_send && !w_full) begin
               w_push       = 1'b1;
               w_state_next = S_ACK;
            end
         end
         S_ACK: begin
            w_ack = 1'b1;
            if (!bus.per_send) begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge per_clock or posedge per_reset) begin
      if (per_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge per_clock or posedge per_reset) begin
      if (per_reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_underflow <= 1'b0;
         r_rx_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
            r_rx_count <= r_rx_count + CNT_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LVL_W'(1);
            2'b01:   r_level <= r_level - LVL_W'(1);
            default: r_level <= r_level;
         endcase
         if (bus.per_pop && w_empty) begin
            r_underflow <= 1'b1;
         end
      end
   end

   // Storage has no reset: clearing the pointers and level already discards its contents.
   always_ff @(posedge per_clock) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= bus.per_dados_in;
      end
   end

   assign bus.per_ack       = w_ack;
   assign bus.per_dados_out = w_empty ? '0 : r_mem[r_rd_ptr];
   assign bus.per_empty     = w_empty;
   assign bus.per_full      = w_full;
   assign bus.per_level     = r_level;
   assign bus.per_underflow = r_underflow;
   assign bus.per_rx_count  = r_rx_count;
endmodule
